morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive side of the Morse link. Converts a serial on/off Morse line, with the same unit timing the Morse generator uses, back into 8-bit ASCII characters.
- Measures mark and space durations in clock cycles, classifies each mark as dot or dash, and accumulates symbols.
- On an inter-character gap, looks up the symbol pattern and presents the ASCII code with a one-cycle valid strobe to the downstream UART TX / FIFO.

Parameters:
- MORSE_CYCLES, 2: clock cycles per Morse unit; must be >= 2.
- MAX_SYMBOLS, 6: maximum symbols per character; symbol shift register width.

Ports:
- clk_i  input  1  system clock
- reset_n_i  input  1  asynchronous active-low reset
- morse_i  input  1  Morse line, 1 = mark (tone on); asynchronous to clk_i
- ascii_o  output  8  decoded character, held until the next valid_o
- valid_o  output  1  one-cycle strobe; ascii_o is valid this cycle
- err_o  output  1  one-cycle strobe coincident with valid_o when the pattern is unknown or overflowed
- busy_o  output  1  high while a character is being received (state != IDLE)

Behaviour:
- Reset: async assert / sync deassert internally. While reset_n_i = 0: ascii_o = 8'h00, valid_o = 0, err_o = 0, busy_o = 0, state = IDLE, all counters and registers cleared. Reset mid-character discards partial symbols with no strobe.
- Input conditioning: 2-flop synchronizer on morse_i. All timing below is relative to the synchronized signal m (2-cycle latency).
- Duration counter `cnt`:
  - Width clog2(8*MORSE_CYCLES)+1, saturating at all-ones (no wrap).
  - Loads 1 on the first cycle of a new level and increments while the level holds.
- Thresholds:
  - DASH_TH = 2*MORSE_CYCLES
  - CHAR_TH = 2*MORSE_CYCLES
  - WORD_TH = 5*MORSE_CYCLES
- States:
  - IDLE: m = 0 and no pending symbols. On m = 1 -> MARK, cnt = 1.
  - MARK: count while m = 1. On m = 0, classify: cnt < DASH_TH is a dot (shift in 0), otherwise a dash (shift in 1). Increment nsym, go to SPACE with cnt = 1. A mark stuck high saturates cnt, still counts as a dash, and has no timeout.
  - SPACE:
    - m = 1 before cnt reaches CHAR_TH: intra-character gap -> MARK.
    - cnt reaches CHAR_TH: emit the character (next cycle valid_o = 1, ascii_o updated), clear the symbol register and nsym, then go to IDLE (or WORD with the feature).
- Symbol register: symbols are stored LSB-first in time order, together with nsym (0..MAX_SYMBOLS).
- Overflow: a symbol arriving with nsym = MAX_SYMBOLS sets a sticky ovf flag and the symbol is dropped. At emit, ovf forces ascii_o = 8'h3F and err_o = 1.
- Lookup table: combinational on (nsym, pattern), covering A-Z (uppercase, 0x41-0x5A) and 0-9 (0x30-0x39). Any other pattern gives 8'h3F ('?') with err_o = 1.
- valid_o / err_o: high for exactly 1 cycle. No backpressure; the consumer must accept every strobe.
- Latency: valid_o rises 2 (sync) + CHAR_TH + 1 cycles after the falling edge of the last mark on morse_i.
- Simultaneous events: reset dominates everything. A rising m in the same cycle cnt reaches CHAR_TH counts as an inter-character gap: the character is emitted and a new character starts in MARK.

Optional Feature:
- Macro: MORSE_DECODER_WORD_SPACE_EN.
- Defined:
  - After an emit, the FSM enters state WORD (busy_o = 0) and keeps counting the low level.
  - If cnt reaches WORD_TH with m still 0, emit 8'h20 (space) with valid_o = 1, err_o = 0, then go to IDLE.
  - If m = 1 first, go to MARK with no space emitted.
  - Exactly one space per gap, however long the gap.
- Undefined: the WORD state is absent, the FSM goes directly to IDLE after an emit, and a space is never emitted.

Test Plan (MORSE_CYCLES = 2, so DASH_TH = 4, CHAR_TH = 4, WORD_TH = 10):
- 'A': mark 2, space 2, mark 6, then line low -> one valid_o with ascii_o = 8'h41, err_o = 0, busy_o low afterwards.
- '9': four 6-cycle marks then one 2-cycle mark, 2-cycle spaces between, then low -> ascii_o = 8'h39. Then 'E' (single 2-cycle mark) -> ascii_o = 8'h45. Exactly two strobes.
- Unknown and overflow: six dots -> 8'h3F with err_o = 1. Seven dots -> 8'h3F with err_o = 1 and no spurious second strobe.
- Reset mid-character: after 2 dots, pulse reset_n_i low for 3 cycles -> outputs return to 0 and there is no strobe. A following 'T' (mark 6) -> 8'h54.
- Boundaries:
  - Mark of exactly 3 cycles -> dot; mark of exactly 4 -> dash.
  - Space of 3 cycles -> same character; space of 4 -> character emitted.
- With MORSE_DECODER_WORD_SPACE_EN: 'E', 12 low cycles, 'E' -> strobes 8'h45, 8'h20, 8'h45. Without the macro -> 8'h45, 8'h45.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse line receiver: times marks/spaces, classifies dot/dash, emits ASCII with a 1-cycle valid_o strobe.
// Latency 2+CHAR_TH+1 cycles from last mark fall; no backpressure. Optional MORSE_DECODER_WORD_SPACE_EN emits word spaces.
module morse_decoder #(
  parameter int MORSE_CYCLES = 2,
  parameter int MAX_SYMBOLS  = 6
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       morse_i,
  output logic [7:0] ascii_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(8*MORSE_CYCLES) + 1;
  localparam int NW = $clog2(MAX_SYMBOLS + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DASH_TH = CW'(2*MORSE_CYCLES);
  localparam logic [CW-1:0] CHAR_TH = CW'(2*MORSE_CYCLES);
`ifdef MORSE_DECODER_WORD_SPACE_EN
  localparam logic [CW-1:0] WORD_TH = CW'(5*MORSE_CYCLES);
`endif
  localparam logic [NW-1:0] NMAX    = NW'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
`ifdef MORSE_DECODER_WORD_SPACE_EN
    , WORD
`endif
  } state_t;

  logic [1:0]             rst_q;
  logic                   rst_n;
  logic                   s1, m;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_inc;
  logic [MAX_SYMBOLS-1:0] sym, sym_n;
  logic [NW-1:0]          nsym, nsym_n;
  logic                   ovf, ovf_n;
  logic [7:0]             ascii_n;
  logic                   valid_n, err_n;
  logic [7:0]             key;
  logic [7:0]             lk_ascii;
  logic                   lk_err;

  // Reset asserts immediately, releases two clocks after reset_n_i rises.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_q <= 2'b00;
    else            rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      m  <= 1'b0;
    end else begin
      s1 <= morse_i;
      m  <= s1;
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

  // Key = leading marker bit followed by symbols in time order (1 = dash).
  always_comb begin
    key = 8'd1;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (i < int'(nsym)) key = {key[6:0], sym[i]};
    end
  end

  always_comb begin
    lk_ascii = 8'h3F;
    lk_err   = 1'b0;
    case (key)
      8'b00000101: lk_ascii = 8'h41; // A .-
      8'b00011000: lk_ascii = 8'h42; // B -...
      8'b00011010: lk_ascii = 8'h43;
      8'b00001100: lk_ascii = 8'h44;
      8'b00000010: lk_ascii = 8'h45;
      8'b00010010: lk_ascii = 8'h46;
      8'b00001110: lk_ascii = 8'h47;
      8'b00010000: lk_ascii = 8'h48;
      8'b00000100: lk_ascii = 8'h49;
      8'b00010111: lk_ascii = 8'h4A;
      8'b00001101: lk_ascii = 8'h4B;
      8'b00010100: lk_ascii = 8'h4C;
      8'b00000111: lk_ascii = 8'h4D;
      8'b00000110: lk_ascii = 8'h4E;
      8'b00001111: lk_ascii = 8'h4F;
      8'b00010110: lk_ascii = 8'h50;
      8'b00011101: lk_ascii = 8'h51;
      8'b00001010: lk_ascii = 8'h52;
      8'b00001000: lk_ascii = 8'h53;
      8'b00000011: lk_ascii = 8'h54;
      8'b00001001: lk_ascii = 8'h55;
      8'b00010001: lk_ascii = 8'h56;
      8'b00001011: lk_ascii = 8'h57;
      8'b00011001: lk_ascii = 8'h58;
      8'b00011011: lk_ascii = 8'h59;
      8'b00011100: lk_ascii = 8'h5A;
      8'b00111111: lk_ascii = 8'h30;
      8'b00101111: lk_ascii = 8'h31;
      8'b00100111: lk_ascii = 8'h32;
      8'b00100011: lk_ascii = 8'h33;
      8'b00100001: lk_ascii = 8'h34;
      8'b00100000: lk_ascii = 8'h35;
      8'b00110000: lk_ascii = 8'h36;
      8'b00111000: lk_ascii = 8'h37;
      8'b00111100: lk_ascii = 8'h38;
      8'b00111110: lk_ascii = 8'h39;
      default: begin
        lk_ascii = 8'h3F;
        lk_err   = 1'b1;
      end
    endcase
    // Longer patterns would alias once the marker shifts out of the key.
    if (int'(nsym) > 5) begin
      lk_ascii = 8'h3F;
      lk_err   = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sym_n   = sym;
    nsym_n  = nsym;
    ovf_n   = ovf;
    ascii_n = ascii_o;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (m) begin
          state_n = MARK;
          cnt_n   = ONE;
        end
      end
      MARK: begin
        if (m) begin
          cnt_n = cnt_inc;
        end else begin
          if (nsym == NMAX) begin
            ovf_n = 1'b1;
          end else begin
            sym_n  = sym | (MAX_SYMBOLS'(cnt >= DASH_TH) << nsym);
            nsym_n = nsym + NW'(1);
          end
          state_n = SPACE;
          cnt_n   = ONE;
        end
      end
      SPACE: begin
        if (cnt >= CHAR_TH) begin
          ascii_n = ovf ? 8'h3F : lk_ascii;
          err_n   = ovf | lk_err;
          valid_n = 1'b1;
          sym_n   = '0;
          nsym_n  = '0;
          ovf_n   = 1'b0;
          // A mark arriving on the emit cycle starts the next character.
          if (m) begin
            state_n = MARK;
            cnt_n   = ONE;
          end else begin
`ifdef MORSE_DECODER_WORD_SPACE_EN
            state_n = WORD;
            cnt_n   = cnt_inc;
`else
            state_n = IDLE;
            cnt_n   = '0;
`endif
          end
        end else if (m) begin
          state_n = MARK;
          cnt_n   = ONE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
`ifdef MORSE_DECODER_WORD_SPACE_EN
      WORD: begin
        if (m) begin
          state_n = MARK;
          cnt_n   = ONE;
        end else if (cnt >= WORD_TH) begin
          ascii_n = 8'h20;
          valid_n = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sym     <= '0;
      nsym    <= '0;
      ovf     <= 1'b0;
      ascii_o <= 8'h00;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sym     <= sym_n;
      nsym    <= nsym_n;
      ovf     <= ovf_n;
      ascii_o <= ascii_n;
      valid_o <= valid_n;
      err_o   <= err_n;
    end
  end

  assign busy_o = (state == MARK) || (state == SPACE);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder at MORSE_CYCLES=2 (dot=2, dash=6, gaps of 2).
module tb_morse_decoder;
  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       morse_i;
  logic [7:0] ascii_o;
  logic       valid_o, err_o, busy_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcyc = 0;
  int fall_cyc = 0;
  int stray = 0;
  bit keep_sp = 1'b0;
  logic [8:0] got_q[$];

  morse_decoder #(.MORSE_CYCLES(2), .MAX_SYMBOLS(6)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .morse_i(morse_i),
    .ascii_o(ascii_o), .valid_o(valid_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Strobe monitor: records {err, ascii} for every valid_o cycle.
  always @(negedge clk_i) begin
    if (err_o && !valid_o) stray++;
    if (valid_o) begin
      vcyc = cyc;
`ifdef MORSE_DECODER_WORD_SPACE_EN
      if (ascii_o != 8'h20 || keep_sp) got_q.push_back({err_o, ascii_o});
`else
      got_q.push_back({err_o, ascii_o});
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    morse_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      line(1'b1, (pat[i] == 8'h2D) ? 6 : 2);
      if (i < pat.len() - 1) line(1'b0, 2);
    end
    fall_cyc = cyc;
    line(1'b0, 20);
  endtask

  task automatic expect_chars(input string tag, input int n,
                              input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
    logic [8:0] ev[3];
    logic [31:0] obs;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (got_q.size() > 0) ? {23'd0, got_q.pop_front()} : 32'hFFFF_FFFF;
      check($sformatf("%s_char%0d", tag, i), obs, {23'd0, ev[i]});
    end
    got_q.delete();
  endtask

  initial begin
    reset_n_i = 1'b0;
    morse_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ascii", ascii_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    reset_n_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // 'A' with latency measurement
    line(1'b1, 2); line(1'b0, 2); line(1'b1, 6);
    check("A_busy_mid", busy_o, 1'b1);
    fall_cyc = cyc;
    line(1'b0, 20);
    expect_chars("A", 1, 9'h041, 9'h0, 9'h0);
    check("A_latency", vcyc - fall_cyc, 7);
    check("A_busy_after", busy_o, 1'b0);
    check("A_hold", ascii_o, 8'h41);

    send("----.");
    send(".");
    expect_chars("9E", 2, 9'h039, 9'h045, 9'h0);

    send("......");
    expect_chars("six_dots", 1, 9'h13F, 9'h0, 9'h0);
    send(".......");
    expect_chars("ovf", 1, 9'h13F, 9'h0, 9'h0);

    // Reset in the middle of a character
    line(1'b1, 2); line(1'b0, 2); line(1'b1, 2); line(1'b0, 1);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_ascii", ascii_o, 8'h00);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_valid", valid_o, 1'b0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    line(1'b0, 20);
    expect_chars("mid_rst_quiet", 0, 9'h0, 9'h0, 9'h0);
    send("-");
    expect_chars("T_after_rst", 1, 9'h054, 9'h0, 9'h0);

    // Mark and space length boundaries
    line(1'b1, 3); line(1'b0, 20);
    expect_chars("mark3", 1, 9'h045, 9'h0, 9'h0);
    line(1'b1, 4); line(1'b0, 20);
    expect_chars("mark4", 1, 9'h054, 9'h0, 9'h0);
    line(1'b1, 2); line(1'b0, 3); line(1'b1, 2); line(1'b0, 20);
    expect_chars("space3", 1, 9'h049, 9'h0, 9'h0);
    line(1'b1, 2); line(1'b0, 4); line(1'b1, 2); line(1'b0, 20);
    expect_chars("space4", 2, 9'h045, 9'h045, 9'h0);

    // Word gap
    keep_sp = 1'b1;
    line(1'b1, 2); line(1'b0, 12); line(1'b1, 2); line(1'b0, 9);
`ifdef MORSE_DECODER_WORD_SPACE_EN
    expect_chars("word", 3, 9'h045, 9'h020, 9'h045);
`else
    expect_chars("word", 2, 9'h045, 9'h045, 9'h0);
`endif
    keep_sp = 1'b0;

    check("stray_err", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
